riscv_mc_control: RTL
=====================

Name: riscv_mc_control

Overview:
- Multi-cycle control FSM for the sequential RV64 core.
- Produces the 4-bit ALU control code and all datapath/memory enables consumed by the 64-bit ALU datapath, and takes the ALU Zero flag back.
- Decodes the subset LD, SD, BEQ, ADD/SUB/AND/OR and ADDI, sequences them over several cycles, and traps on illegal opcodes or memory timeouts.

Parameters:
- MEM_TIMEOUT, 255: maximum cycles a memory request waits for mem_ready before trapping; legal range 1..255.
- ADDI_EN, 1: when 1, ADDI is decoded; when 0, opcode 0010011 is illegal.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  7  instruction register bits [6:0].
- funct3  in  3  instruction register bits [14:12].
- funct7_5  in  1  instruction register bit 30.
- zero  in  1  ALU Zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write, 0 = read; valid only with mem_req.
- addr_src  out  1  0 = PC, 1 = ALUOut.
- ir_write  out  1  load instruction register and OldPC.
- pc_write  out  1  load PC from the result mux.
- reg_write  out  1  register file write enable.
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rs1 data.
- alu_src_b  out  2  00 = rs2 data, 01 = immediate, 10 = constant 4.
- alu_control  out  4  0000 = AND, 0001 = OR, 0010 = ADD, 0110 = SUB.
- result_src  out  2  00 = ALU result, 01 = ALUOut, 10 = memory data.
- retire  out  1  one-cycle pulse when an instruction completes.
- trap  out  1  sticky error flag.
- trap_cause  out  2  01 = illegal instruction, 10 = memory timeout.
- state_o  out  4  current state encoding, for debug.

Behaviour:
- Reset: asynchronous, enters S_RESET (0). All outputs are 0, trap_cause = 00, timeout counter = 0.
- Next state after reset: S_RESET goes to S_FETCH on the first clock after rst_n deasserts. S_RESET drives no enables.
- Output types: all outputs are combinational from the registered state. Exceptions: pc_write in S_BEQ and the mem_ready-qualified enables below.
- Default alu_control is ADD unless a state says otherwise.
- S_FETCH (1):
  - Drives mem_req=1, mem_we=0, addr_src=0, alu_src_a=00, alu_src_b=10, ADD, result_src=00.
  - When mem_ready=1: ir_write=1 and pc_write=1 in the same cycle, then go to S_DECODE. Otherwise stay.
- S_DECODE (2):
  - Drives alu_src_a=01, alu_src_b=01, ADD; the branch target lands in ALUOut.
  - Next state by opcode: 0000011 with funct3=011, or 0100011 with funct3=011, go to S_MEMADR. 0110011 goes to S_EXECR. 0010011 with funct3=000 and ADDI_EN=1 goes to S_EXECI. 1100011 with funct3=000 goes to S_BEQ.
  - Anything else goes to S_TRAP with cause 01.
- S_MEMADR (3): drives alu_src_a=10, alu_src_b=01, ADD. Goes to S_MEMRD for LD, S_MEMWR for SD. The decode inputs are stable because the IR is held.
- S_MEMRD (4): drives mem_req=1, mem_we=0, addr_src=1. On mem_ready, go to S_MEMWB.
- S_MEMWB (5): drives reg_write=1, result_src=10, retire=1. Goes to S_FETCH.
- S_MEMWR (6): drives mem_req=1, mem_we=1, addr_src=1. On mem_ready: retire=1, go to S_FETCH.
- S_EXECR (7): drives alu_src_a=10, alu_src_b=00. Goes to S_ALUWB.
  - funct3=000, funct7_5=0 gives ADD.
  - funct3=000, funct7_5=1 gives SUB.
  - funct3=111 gives AND.
  - funct3=110 gives OR.
  - Any other funct3 goes to S_TRAP with cause 01; reg_write is never asserted for it.
- S_EXECI (8): drives alu_src_a=10, alu_src_b=01, ADD. Goes to S_ALUWB.
- S_ALUWB (9): drives reg_write=1, result_src=01, retire=1. Goes to S_FETCH.
- S_BEQ (10): drives alu_src_a=10, alu_src_b=00, SUB, result_src=01, pc_write=zero (Mealy), retire=1. Goes to S_FETCH.
- S_TRAP (11):
  - All enables and mem_req are 0; trap=1 and trap_cause is held.
  - Only reset exits this state.
- Timeout counter (8-bit):
  - Clears on entry to S_FETCH, S_MEMRD and S_MEMWR.
  - Increments each cycle the block is in one of those states with mem_ready=0.
  - When the count equals MEM_TIMEOUT and mem_ready=0, go to S_TRAP with cause 10.
  - mem_ready=1 in the same cycle as the timeout wins: the block proceeds normally.
- Invariants:
  - mem_req is never asserted in S_RESET, S_DECODE or S_TRAP.
  - reg_write and pc_write are never both 1 in S_FETCH/S_MEMWB.
  - At most one retire per instruction.
- Reset mid-operation: an in-flight memory request is dropped immediately (mem_req goes to 0 asynchronously), and the block returns to S_RESET.

Test Plan:
- Reset then FETCH with mem_ready held 1:
  - First cycle after reset: state_o=0, all enables 0.
  - Next cycle: state_o=1, mem_req=1, ir_write=pc_write=1.
- R-type sequence: opcode=0110011, funct3=000, funct7_5=1.
  - S_EXECR shows alu_control=0110.
  - S_ALUWB shows reg_write=1, result_src=01, retire=1.
  - Total 4 cycles, FETCH to FETCH, with 0-wait memory.
- BEQ: run once with zero=1 and once with zero=0.
  - zero=1: S_BEQ has pc_write=1, alu_control=0110.
  - zero=0: pc_write=0.
  - Both cases return to FETCH with retire=1.
- LD with mem_ready delayed 3 cycles in S_MEMRD:
  - mem_req=1, addr_src=1 is held for 4 cycles.
  - S_MEMWB then shows result_src=10, reg_write=1.
  - SD: mem_we=1, retire on the accept cycle.
- Illegal opcode 1111111:
  - S_DECODE goes to S_TRAP with trap=1, trap_cause=01.
  - Stays there for 20 cycles with mem_req=0.
  - rst_n pulse clears to state 0.
- Timeout, MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH:
  - trap_cause=10 after 5 FETCH cycles.
  - Repeat with mem_ready=1 on the limit cycle: normal decode, no trap.

Source files
------------

// File: rtl/riscv_mc_control.sv
// rtl/riscv_mc_control.sv - multi-cycle control FSM for the sequential RV64 core
module riscv_mc_control #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter bit          ADDI_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_control,
  output logic [1:0] result_src,
  output logic       retire,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXECR  = 4'd7,
    S_EXECI  = 4'd8,
    S_ALUWB  = 4'd9,
    S_BEQ    = 4'd10,
    S_TRAP   = 4'd11
  } state_t;

  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  localparam logic [7:0] TMO_LIMIT = MEM_TIMEOUT[7:0];

  state_t     state_q, state_d;
  logic [1:0] cause_q, cause_d;
  logic [7:0] cnt_q, cnt_d;
  logic       timeout;
  logic       mem_state;

  // A wait expires only when the limit is reached and memory is still not ready
  assign timeout   = (cnt_q == TMO_LIMIT) && !mem_ready;
  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

  // Next-state, trap cause and timeout counter update
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (((opcode == OP_LD) || (opcode == OP_SD)) && (funct3 == 3'b011)) begin
          state_d = S_MEMADR;
        end else if (opcode == OP_R) begin
          state_d = S_EXECR;
        end else if (ADDI_EN && (opcode == OP_ADDI) && (funct3 == 3'b000)) begin
          state_d = S_EXECI;
        end else if ((opcode == OP_BEQ) && (funct3 == 3'b000)) begin
          state_d = S_BEQ;
        end else begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      // IR is held, so the opcode still tells LD from SD here
      S_MEMADR: state_d = (opcode == OP_SD) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_EXECR: begin
        if ((funct3 == 3'b000) || (funct3 == 3'b111) || (funct3 == 3'b110)) begin
          state_d = S_ALUWB;
        end else begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      S_EXECI:  state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BEQ:    state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_RESET;
    endcase

    // Counter restarts on every state change, counts stalled memory cycles otherwise
    if (state_d != state_q) begin
      cnt_d = 8'd0;
    end else if (mem_state && !mem_ready) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, cause and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      cause_q <= 2'b00;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  // Datapath controls decoded from the current state; a few are qualified by mem_ready/zero
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_src    = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    result_src  = 2'b00;
    retire      = 1'b0;
    case (state_q)
      S_RESET:  alu_control = 4'b0000;
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b10;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMRD: begin
        mem_req  = 1'b1;
        addr_src = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        result_src = 2'b10;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_src = 1'b1;
        retire   = mem_ready;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        case (funct3)
          3'b000:  alu_control = funct7_5 ? ALU_SUB : ALU_ADD;
          3'b111:  alu_control = ALU_AND;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_ADD;
        endcase
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        result_src = 2'b01;
        retire     = 1'b1;
      end
      S_BEQ: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        result_src  = 2'b01;
        pc_write    = zero;
        retire      = 1'b1;
      end
      default: ;
    endcase
  end

  assign trap       = (state_q == S_TRAP);
  assign trap_cause = cause_q;
  assign state_o    = state_q;

endmodule
